bk_sector_sched: RTL and testbench

- Sequences backup-RAM (BSRAM) transfers between the on-chip BSRAM and the mounted save image, one 512-byte sector at a time, over the hps_io sd_lba/sd_rd/sd_wr/sd_ack handshake.
- Sources of work: manual Load/Save menu requests, and an automatic load when a ROM download ends.
- Tracks a dirty flag from BSRAM writes and reports busy, loading and error status.
- Sits in emu between hps_io and the bsram dpram port B; the loading output feeds the system reset term.

---
 rtl/bk_sector_sched_if.sv | 31 +++
 rtl/bk_sector_sched.sv | 174 +++++++++++++++++
 tb/tb_bk_sector_sched.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/bk_sector_sched_if.sv
// -----------------------------------------------------------------------------
// bk_sector_sched_if
// Sector handshake between the backup-RAM scheduler and hps_io.
//   sd_lba  : sector number for the current request (scheduler -> hps_io)
//   sd_rd   : sector read request, image -> BSRAM  (scheduler -> hps_io)
//   sd_wr   : sector write request, BSRAM -> image (scheduler -> hps_io)
//   sd_ack  : hps_io acknowledge level, high while the sector is moving
// Modports: master = scheduler side, slave = hps_io side.
// -----------------------------------------------------------------------------
interface bk_sector_sched_if #(
    parameter int LBA_W = 32
);
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface

// File: rtl/bk_sector_sched.sv
// -----------------------------------------------------------------------------
// bk_sector_sched
// Moves the on-chip backup RAM to/from the mounted save image one 512-byte
// sector at a time. Work comes from Load/Save menu edges and from the end of a
// ROM download (automatic load). Also tracks whether BSRAM was modified.
//
// Ports:
//   clk_sys   : system clock
//   reset     : asynchronous active-high reset
//   ena       : save image mounted, nonzero size and writable
//   load_req  : level, rising edge requests a load
//   save_req  : level, rising edge requests a save
//   dl_done   : one-cycle pulse at the end of a ROM download
//   ram_mask  : BSRAM byte mask (size-1); zero means no BSRAM
//   bsram_wr  : one-cycle pulse per CPU write to BSRAM
//   sd        : sector handshake to hps_io (master side)
//   busy      : transfer in progress
//   loading   : current transfer is a load (feeds the system reset term)
//   dirty     : BSRAM modified since last completed load/save
//   err       : sticky, last transfer aborted waiting for sd_ack
// -----------------------------------------------------------------------------
module bk_sector_sched #(
    parameter int          MASK_W  = 24,
    parameter int          LBA_W   = 32,
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ena,
    input  logic                load_req,
    input  logic                save_req,
    input  logic                dl_done,
    input  logic [MASK_W-1:0]   ram_mask,
    input  logic                bsram_wr,
    bk_sector_sched_if.master   sd,
    output logic                busy,
    output logic                loading,
    output logic                dirty,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } state_t;

    state_t             state_reg;
    logic [LBA_W-1:0]   lba_reg;
    logic               rd_reg;
    logic               wr_reg;
    logic               busy_reg;
    logic               loading_reg;
    logic               dirty_reg;
    logic               err_reg;
    logic [23:0]        cnt_reg;

    // Edge-detect history. armed_reg masks request edges on the first clock
    // after reset, so a menu level already high at release does not fire.
    logic               load_q_reg;
    logic               save_q_reg;
    logic               ack_q_reg;
    logic               armed_reg;

    logic               load_edge;
    logic               save_edge;
    logic               load_go;
    logic               ack_rise;
    logic               ack_fall;
    logic               mask_nz;
    logic [LBA_W-1:0]   last_lba;

    assign load_edge = armed_reg & load_req & ~load_q_reg;
    assign save_edge = armed_reg & save_req & ~save_q_reg;
    assign load_go   = load_edge | dl_done;
    assign ack_rise  = sd.sd_ack & ~ack_q_reg;
    assign ack_fall  = ~sd.sd_ack & ack_q_reg;
    assign mask_nz   = (ram_mask != '0);
    assign last_lba  = LBA_W'(ram_mask[MASK_W-1:9]);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            lba_reg     <= '0;
            rd_reg      <= 1'b0;
            wr_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            loading_reg <= 1'b0;
            dirty_reg   <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            load_q_reg  <= 1'b0;
            save_q_reg  <= 1'b0;
            ack_q_reg   <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            load_q_reg <= load_req;
            save_q_reg <= save_req;
            ack_q_reg  <= sd.sd_ack;
            armed_reg  <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    // Load (menu or post-download) beats a simultaneous save.
                    if (ena && mask_nz && (load_go || save_edge)) begin
                        state_reg   <= ST_REQ;
                        lba_reg     <= '0;
                        busy_reg    <= 1'b1;
                        loading_reg <= load_go;
                        rd_reg      <= load_go;
                        wr_reg      <= ~load_go;
                        err_reg     <= 1'b0;
                        cnt_reg     <= '0;
                    end
                end

                ST_REQ: begin
                    if (ack_rise) begin
                        rd_reg    <= 1'b0;
                        wr_reg    <= 1'b0;
                        state_reg <= ST_XFER;
                    end else if (cnt_reg == TIMEOUT - 24'd1) begin
                        // hps_io never answered: give up, leave dirty alone.
                        rd_reg      <= 1'b0;
                        wr_reg      <= 1'b0;
                        busy_reg    <= 1'b0;
                        loading_reg <= 1'b0;
                        err_reg     <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 24'd1;
                    end
                end

                ST_XFER: begin
                    // hps_io owns the sector until ack drops; no timeout here.
                    if (ack_fall) begin
                        if (lba_reg == last_lba) begin
                            busy_reg    <= 1'b0;
                            loading_reg <= 1'b0;
                            dirty_reg   <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end else begin
                            // Request type is implied by loading_reg.
                            lba_reg   <= lba_reg + 1'b1;
                            rd_reg    <= loading_reg;
                            wr_reg    <= ~loading_reg;
                            cnt_reg   <= '0;
                            state_reg <= ST_REQ;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase

            // Placed after the completion clear so a CPU write landing on the
            // final save cycle keeps the image marked stale. Writes during a
            // load come from hps_io itself and are not CPU modifications.
            if (bsram_wr && !loading_reg) begin
                dirty_reg <= 1'b1;
            end
        end
    end

    assign sd.sd_lba = lba_reg;
    assign sd.sd_rd  = rd_reg;
    assign sd.sd_wr  = wr_reg;
    assign busy      = busy_reg;
    assign loading   = loading_reg;
    assign dirty     = dirty_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bk_sector_sched.sv
// -----------------------------------------------------------------------------
// tb_bk_sector_sched
// Directed bench for bk_sector_sched with a short ack timeout (16 cycles).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_bk_sector_sched;

    localparam int MASK_W = 24;
    localparam int LBA_W  = 32;

    logic              clk_sys;
    logic              reset;
    logic              ena;
    logic              load_req;
    logic              save_req;
    logic              dl_done;
    logic [MASK_W-1:0] ram_mask;
    logic              bsram_wr;
    logic              busy;
    logic              loading;
    logic              dirty;
    logic              err;

    int checks;
    int errors;

    bk_sector_sched_if #(.LBA_W(LBA_W)) sd_bus ();

    bk_sector_sched #(
        .MASK_W  (MASK_W),
        .LBA_W   (LBA_W),
        .TIMEOUT (24'd16)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ena      (ena),
        .load_req (load_req),
        .save_req (save_req),
        .dl_done  (dl_done),
        .ram_mask (ram_mask),
        .bsram_wr (bsram_wr),
        .sd       (sd_bus.master),
        .busy     (busy),
        .loading  (loading),
        .dirty    (dirty),
        .err      (err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sector handshake: ack rise (request must drop), then ack fall.
    task automatic ack_sector(input string tag);
        sd_bus.sd_ack = 1'b1;
        tick(1);
        chk({tag, "_req_drop"}, {30'd0, sd_bus.sd_rd, sd_bus.sd_wr}, 32'd0);
        sd_bus.sd_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        ena           = 1'b0;
        load_req      = 1'b0;
        save_req      = 1'b0;
        dl_done       = 1'b0;
        ram_mask      = '0;
        bsram_wr      = 1'b0;
        sd_bus.sd_ack = 1'b0;

        // ---- reset state ----
        tick(2);
        chk("rst_lba",   sd_bus.sd_lba, 32'd0);
        chk("rst_flags", {26'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading, dirty, err}, 32'd0);
        reset = 1'b0;
        tick(2);

        // ---- 4-sector load, ram_mask 0x7FF -> LBA 0..3 ----
        ena      = 1'b1;
        ram_mask = 24'h0007FF;
        load_req = 1'b1;
        tick(1);
        chk("ld_start", {28'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading}, 32'b1011);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("ld_lba%0d", s), sd_bus.sd_lba, s);
            chk($sformatf("ld_rd%0d", s), {30'd0, sd_bus.sd_rd, sd_bus.sd_wr}, 32'b10);
            ack_sector($sformatf("ld%0d", s));
        end
        chk("ld_done", {28'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading}, 32'd0);
        chk("ld_lba_hold", sd_bus.sd_lba, 32'd3);
        load_req = 1'b0;
        tick(1);

        // ---- CPU write, then 1-sector save (ram_mask 0x1FF) ----
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        chk("dirty_set", {31'd0, dirty}, 32'd1);
        ram_mask = 24'h0001FF;
        save_req = 1'b1;
        tick(1);
        chk("sv_start", {27'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading, dirty}, 32'b01101);
        chk("sv_lba", sd_bus.sd_lba, 32'd0);
        ack_sector("sv0");
        chk("sv_done", {29'd0, busy, dirty, sd_bus.sd_wr}, 32'd0);
        save_req = 1'b0;
        tick(1);

        // ---- simultaneous load+save: load wins; save during busy ignored ----
        ram_mask = 24'h0003FF;   // 2 sectors
        load_req = 1'b1;
        save_req = 1'b1;
        tick(1);
        chk("both_rd", {30'd0, sd_bus.sd_rd, sd_bus.sd_wr}, 32'b10);
        load_req = 1'b0;
        save_req = 1'b0;
        tick(1);
        save_req = 1'b1;         // edge while busy
        tick(1);
        // bsram_wr during the load handshake must not set dirty
        sd_bus.sd_ack = 1'b1;
        bsram_wr      = 1'b1;
        tick(1);
        bsram_wr      = 1'b0;
        sd_bus.sd_ack = 1'b0;
        tick(1);
        chk("both_lba1", sd_bus.sd_lba, 32'd1);
        chk("both_rd1", {30'd0, sd_bus.sd_rd, sd_bus.sd_wr}, 32'b10);
        ack_sector("both1");
        tick(3);
        chk("both_nosave", {28'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, dirty}, 32'd0);
        save_req = 1'b0;
        tick(1);

        // ---- dl_done gating ----
        ena     = 1'b0;
        dl_done = 1'b1;
        tick(1);
        dl_done = 1'b0;
        tick(1);
        chk("dl_noena", {29'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy}, 32'd0);
        ena      = 1'b1;
        ram_mask = '0;
        dl_done  = 1'b1;
        tick(1);
        dl_done  = 1'b0;
        tick(1);
        chk("dl_nomask", {29'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy}, 32'd0);
        ram_mask = 24'h0001FF;
        dl_done  = 1'b1;
        tick(1);
        dl_done  = 1'b0;
        chk("dl_start", {28'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading}, 32'b1011);
        ack_sector("dl0");
        chk("dl_done", {31'd0, busy}, 32'd0);
        tick(1);

        // ---- timeout: dirty set beforehand must survive the abort ----
        bsram_wr = 1'b1;
        tick(1);
        bsram_wr = 1'b0;
        load_req = 1'b1;
        tick(1);                 // REQ entered, counter 0
        tick(15);                // counter now 15, still waiting
        chk("to_wait", {29'd0, sd_bus.sd_rd, busy, err}, 32'b110);
        tick(1);
        chk("to_abort", {27'd0, sd_bus.sd_rd, busy, loading, err, dirty}, 32'b00011);
        load_req = 1'b0;
        tick(1);

        // ---- next valid save clears err; coincident bsram_wr keeps dirty ----
        save_req = 1'b1;
        tick(1);
        chk("err_clr", {30'd0, err, sd_bus.sd_wr}, 32'b01);
        sd_bus.sd_ack = 1'b1;
        tick(1);
        sd_bus.sd_ack = 1'b0;
        bsram_wr      = 1'b1;
        tick(1);
        bsram_wr      = 1'b0;
        chk("sv_coinc", {30'd0, busy, dirty}, 32'b01);
        save_req = 1'b0;
        tick(1);

        // ---- reset during XFER of sector 2 ----
        ram_mask = 24'h0007FF;
        load_req = 1'b1;
        tick(1);
        ack_sector("rx0");
        ack_sector("rx1");
        sd_bus.sd_ack = 1'b1;
        tick(1);
        chk("rx_lba2", sd_bus.sd_lba, 32'd2);
        reset = 1'b1;
        #1;
        chk("rx_async_lba", sd_bus.sd_lba, 32'd0);
        chk("rx_async_flags", {26'd0, sd_bus.sd_rd, sd_bus.sd_wr, busy, loading, dirty, err}, 32'd0);
        sd_bus.sd_ack = 1'b0;
        tick(1);
        reset = 1'b0;            // load_req still high: must not trigger
        tick(3);
        chk("rx_no_retrig", {29'd0, sd_bus.sd_rd, busy, loading}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
